// File: rtl/result_tx_fmt_pkg.sv
// Shared encodings for the result transmit path: emit FSM states,
// ASCII constants and the double-dabble digit adjust.
package result_tx_fmt_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CONV,
      SIGN,
      HUND,
      TENS,
      UNITS,
      CR,
      LF,
      FIN
   } state_t;

   localparam logic [7:0] ASCII_NUL   = 8'h00;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift / add-3).
// The first shift happens as part of the load, so the digits are final 7 edges later.
module bin2bcd8
   import result_tx_fmt_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       load,
   input  logic [7:0] din,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] units,
   output logic       done
);

   logic [11:0] bcd;
   logic [7:0]  sr;
   logic [2:0]  cnt;
   logic [3:0]  adj_t;
   logic [3:0]  adj_u;

   assign adj_t = add3(bcd[7:4]);
   assign adj_u = add3(bcd[3:0]);

   // Hundreds never exceeds 1 before the last shift, so it needs no adjust.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         bcd  <= '0;
         sr   <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (load) begin
         bcd  <= {11'd0, din[7]};
         sr   <= {din[6:0], 1'b0};
         cnt  <= 3'd7;
         done <= 1'b0;
      end else if (cnt != 3'd0) begin
         bcd  <= {bcd[10:8], adj_t, adj_u, sr[7]};
         sr   <= {sr[6:0], 1'b0};
         cnt  <= cnt - 3'd1;
         done <= (cnt == 3'd1);
      end
   end

   assign hund  = bcd[11:8];
   assign tens  = bcd[7:4];
   assign units = bcd[3:0];

endmodule

// File: rtl/result_tx_fmt.sv
// Formats an ALU result as decimal ASCII ("[-]digits\r\n") into the TX FIFO,
// with leading-zero suppression and FIFO back-pressure.
module result_tx_fmt
   import result_tx_fmt_pkg::*;
#(
   parameter int SIGNED_MODE = 0,
   parameter int NBIT        = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [NBIT-1:0] RESULT,
   input  logic            FIFO_full,
   output logic [7:0]      data_out,
   output logic            WR_FIFO,
   output logic            BUSY,
   output logic            DONE
);

   state_t     state, state_n, first_dig;
   logic       load, neg_in, neg_q, bcd_done, emit;
   logic [7:0] mag;
   logic [3:0] hund, tens, units;

   assign load   = (state == IDLE) && START;
   assign neg_in = (SIGNED_MODE != 0) && RESULT[7];
   assign mag    = neg_in ? (~RESULT[7:0] + 8'd1) : RESULT[7:0];

   bin2bcd8 u_bcd (
      .CLK   (CLK),
      .RESET (RESET),
      .load  (load),
      .din   (mag),
      .hund  (hund),
      .tens  (tens),
      .units (units),
      .done  (bcd_done)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         neg_q <= 1'b0;
      end else begin
         state <= state_n;
         if (load)
            neg_q <= neg_in;
      end
   end

   assign first_dig = (hund != 4'd0) ? HUND :
                      (tens != 4'd0) ? TENS : UNITS;

   always_comb begin
      state_n  = state;
      data_out = ASCII_NUL;
      emit     = 1'b0;
      DONE     = 1'b0;
      unique case (state)
         IDLE:  if (START) state_n = CONV;
         CONV:  if (bcd_done) state_n = neg_q ? SIGN : first_dig;
         SIGN: begin
            emit     = 1'b1;
            data_out = ASCII_MINUS;
            state_n  = first_dig;
         end
         HUND: begin
            emit     = 1'b1;
            data_out = ASCII_ZERO + {4'd0, hund};
            state_n  = TENS;
         end
         TENS: begin
            emit     = 1'b1;
            data_out = ASCII_ZERO + {4'd0, tens};
            state_n  = UNITS;
         end
         UNITS: begin
            emit     = 1'b1;
            data_out = ASCII_ZERO + {4'd0, units};
            state_n  = CR;
         end
         CR: begin
            emit     = 1'b1;
            data_out = ASCII_CR;
            state_n  = LF;
         end
         LF: begin
            emit     = 1'b1;
            data_out = ASCII_LF;
            state_n  = FIN;
         end
         FIN: begin
            DONE    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Back-pressure: hold the character until the FIFO takes it.
      WR_FIFO = emit & ~FIFO_full;
      if (emit && FIFO_full)
         state_n = state;
   end

   assign BUSY = (state != IDLE);

endmodule
